// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : RV32 instruction-fetch controller: owns the PC, keeps one imem
//            request in flight, buffers one instruction into IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            fault
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic              drop_q;
    logic              if_valid_q;
    logic [XLEN-1:0]   if_pc_q;
    logic [31:0]       if_instr_q;
    logic              fault_q;

    logic              w_consume;
    logic              w_req;
    logic              w_misaligned;
    logic [XLEN-1:0]   w_pc_inc;

    // A request only leaves when the output register will have room for its reply.
    always_comb begin
        w_consume    = if_valid_q && !stall;
        w_req        = (state_q == S_FETCH) && (!if_valid_q || !stall)
                       && !redirect_valid && !reset;
        w_misaligned = (redirect_target[1:0] != 2'b00);
        w_pc_inc     = pc_q + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= RESET_PC;
            if_instr_q <= C_NOP;
            fault_q    <= 1'b0;
        end else if (state_q == S_FAULT) begin
            if_valid_q <= 1'b0;
            fault_q    <= 1'b1;
        end else if (redirect_valid) begin
            pc_q       <= redirect_target;
            if_valid_q <= 1'b0;
            if (w_misaligned) begin
                state_q <= S_FAULT;
                fault_q <= 1'b1;
                drop_q  <= 1'b0;
            end else if (state_q == S_WAIT) begin
                // The in-flight reply belongs to the old path and must never be loaded.
                if (imem_rsp_valid) begin
                    state_q <= S_FETCH;
                    drop_q  <= 1'b0;
                end else begin
                    drop_q  <= 1'b1;
                end
            end
        end else begin
            if (w_consume) begin
                if_valid_q <= 1'b0;
            end
            if (state_q == S_FETCH) begin
                if (w_req && imem_req_ready) begin
                    state_q <= S_WAIT;
                end
            end else if (imem_rsp_valid) begin
                state_q <= S_FETCH;
                if (drop_q) begin
                    drop_q <= 1'b0;
                end else begin
                    if_valid_q <= 1'b1;
                    if_pc_q    <= pc_q;
                    if_instr_q <= imem_rsp_data;
                    pc_q       <= w_pc_inc;
                end
            end
        end
    end

    assign imem_req_valid = w_req;
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign fault          = fault_q;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the single-issue RV32 core.
- Owns the architectural PC register and issues one outstanding instruction-memory request at a time over a valid/ready handshake.
- Buffers the returned instruction into a one-entry IF/ID output register.
- Applies control-flow redirects from the next-PC logic (branch/JAL/JALR target), and discards any response that was in flight when the redirect hit.

Parameters:
- XLEN, 32, address/PC width in bits.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  one clock; synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_rsp_valid  in  1  response valid, one per accepted request, any number of cycles later.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle pulse: taken branch, JAL or JALR.
- redirect_target  in  XLEN  new PC from the next-PC logic.
- stall  in  1  decode cannot accept if_* this cycle.
- if_valid  out  1  output register holds an instruction.
- if_pc  out  XLEN  PC of if_instr.
- if_instr  out  32  fetched instruction.
- fault  out  1  sticky misaligned-target fault.

Behaviour:
- Reset (reset=1 at edge):
  - pc=RESET_PC, state=FETCH, drop=0.
  - if_valid=0, if_pc=RESET_PC, if_instr=32'h0000_0013 (NOP), fault=0.
  - imem_req_valid is 0 while reset is high.
- A reset that lands mid-WAIT abandons the transaction. A response arriving while in FETCH is ignored.
- imem_req_addr = pc at all times.
- Consume: if_valid && !stall. The output register empties on consume unless it is reloaded in the same cycle.
- State FETCH:
  - imem_req_valid = (!if_valid || !stall) && !redirect_valid.
  - On the handshake (valid && ready) go to WAIT.
  - While not ready, valid and addr stay stable except when a redirect changes pc.
- State WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with drop=1: discard the data, clear drop, go to FETCH.
  - On imem_rsp_valid with drop=0: load if_valid=1, if_pc=pc, if_instr=imem_rsp_data; set pc=pc+4; go to FETCH.
- State FAULT:
  - imem_req_valid=0, if_valid=0, fault=1.
  - Left only by reset.
- Redirect, accepted in any non-FAULT state; it has priority over stall and over response loading:
  - pc=redirect_target and if_valid=0 (flush).
  - drop=1 if in WAIT without imem_rsp_valid this cycle.
  - If in WAIT with imem_rsp_valid this cycle, the response is discarded and the state goes to FETCH with drop=0.
  - Misaligned target: if redirect_target[1:0]!=0, go to FAULT instead. pc still takes the target value for debug.
- Arithmetic:
  - pc+4 is modulo 2^XLEN (32'hFFFF_FFFC -> 0).
  - No other PC arithmetic is done here.
- Latency:
  - Redirect at cycle N -> request with the target at N+1.
  - Response at cycle M -> if_valid at M+1.
  - Peak throughput is one instruction per 2 cycles with a 1-cycle memory.
- Stall:
  - The output register holds unchanged.
  - A new request issues only once the output register is free or being consumed.
  - At most one instruction is buffered; nothing is ever overwritten while if_valid && stall.
- Invariants:
  - Never more than one request outstanding.
  - No instruction from a pre-redirect address ever reaches if_valid=1.

Test Plan:
- Reset, then imem ready=1 with a 1-cycle response returning addr^32'hA5A5_0000 -> requests at 0,4,8; if_pc 0,4,8 with matching if_instr; if_valid pulses every 2nd cycle.
- stall=1 for 5 cycles while if_valid=1 with if_pc=4 -> if_pc/if_instr hold; no request issues; after stall drops, next request addr=8.
- redirect_valid with target=32'h100 while in WAIT for addr 8; response arrives 3 cycles later -> response dropped, if_valid stays 0, next request addr=32'h100.
- redirect with target=32'h40 in the same cycle as imem_rsp_valid -> response discarded, if_valid=0, next request addr=32'h40, drop=0.
- PC at 32'hFFFF_FFFC, response returned -> if_pc=32'hFFFF_FFFC, next request addr=0.
- redirect with target=32'h102 -> fault=1, imem_req_valid=0 indefinitely; reset -> fault=0, request at RESET_PC.
